valid_table: RTL and testbench



---
 rtl/valid_table_pkg.sv | 23 ++
 rtl/vt_port_decode.sv | 24 ++
 rtl/valid_table.sv | 87 ++++++++
 tb/tb_valid_table.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/valid_table_pkg.sv
// Shared constants, index type and population-count helper for the valid/busy bit table.
package valid_table_pkg;

  localparam int VT_ENTRIES     = 64;
  localparam int VT_IDX_W       = $clog2(VT_ENTRIES);
  localparam int VT_NUM_CLR     = 2;
  localparam int VT_NUM_SET     = 2;
  localparam int VT_NUM_RD      = 4;
  localparam int VT_MAX_ENTRIES = 1024;

  typedef logic [VT_IDX_W-1:0] vt_idx_t;

  // Callers zero-extend their vector to VT_MAX_ENTRIES; the zero bits fold away.
  function automatic logic [31:0] vt_popcount(input logic [VT_MAX_ENTRIES-1:0] bits);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < VT_MAX_ENTRIES; i++) begin
      n = n + {31'b0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/vt_port_decode.sv
// ORs the one-hot decode of several enabled index ports into one ENTRIES-wide hit vector.
module vt_port_decode #(
  parameter int ENTRIES   = 64,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]       en,
  input  logic [NUM_PORTS*IDX_W-1:0] idx,
  output logic [ENTRIES-1:0]         hit
);

  // Indices at or beyond ENTRIES never match any entry, so they drop out naturally.
  always_comb begin
    hit = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (en[p] && (idx[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
          hit[e] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/valid_table.sv
// Multi-port valid/busy bit table with branch checkpoint snapshot and registered popcount.
// Optional same-cycle set-to-read bypass when VALID_TABLE_BYPASS_EN is defined.
module valid_table
  import valid_table_pkg::*;
#(
  parameter int   ENTRIES   = VT_ENTRIES,
  parameter int   IDX_W     = $clog2(ENTRIES),
  parameter int   NUM_CLR   = VT_NUM_CLR,
  parameter int   NUM_SET   = VT_NUM_SET,
  parameter int   NUM_RD    = VT_NUM_RD,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CLR-1:0]       clr_en_i,
  input  logic [NUM_CLR*IDX_W-1:0] clr_idx_i,
  input  logic [NUM_SET-1:0]       set_en_i,
  input  logic [NUM_SET*IDX_W-1:0] set_idx_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx_i,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     ckpt_save_i,
  input  logic                     ckpt_restore_i,
  output logic [IDX_W:0]           count_o
);

  logic [ENTRIES-1:0]        vld;
  logic [ENTRIES-1:0]        snap;
  logic [ENTRIES-1:0]        vld_next;
  logic [ENTRIES-1:0]        snap_next;
  logic [ENTRIES-1:0]        clr_hit;
  logic [ENTRIES-1:0]        set_hit;
  logic [VT_MAX_ENTRIES-1:0] pc_in;
  logic [IDX_W:0]            count_next;

  vt_port_decode #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .NUM_PORTS(NUM_CLR)) u_clr_decode (
    .en  (clr_en_i),
    .idx (clr_idx_i),
    .hit (clr_hit)
  );

  vt_port_decode #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .NUM_PORTS(NUM_SET)) u_set_decode (
    .en  (set_en_i),
    .idx (set_idx_i),
    .hit (set_hit)
  );

  // Restore overrides clears; writebacks always land, even on a squashed path.
  assign vld_next  = ckpt_restore_i ? (snap | set_hit) : ((vld | set_hit) & ~clr_hit);
  assign snap_next = (ckpt_save_i && !ckpt_restore_i) ? vld_next : (snap | set_hit);

  always_comb begin
    pc_in               = '0;
    pc_in[ENTRIES-1:0]  = vld_next;
    count_next          = (IDX_W+1)'(vt_popcount(pc_in));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= {ENTRIES{RESET_VAL}};
      snap    <= {ENTRIES{RESET_VAL}};
      count_o <= (IDX_W+1)'(RESET_VAL ? ENTRIES : 0);
    end else begin
      vld     <= vld_next;
      snap    <= snap_next;
      count_o <= count_next;
    end
  end

  // Read mux by entry compare so out-of-range indices return 0.
  always_comb begin
    rd_valid_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (rd_idx_i[k*IDX_W +: IDX_W] == IDX_W'(e)) begin
`ifdef VALID_TABLE_BYPASS_EN
          rd_valid_o[k] = rd_en_i[k] &
                          (vld[e] | (set_hit[e] & ~clr_hit[e] & ~(ckpt_restore_i & ~snap[e])));
`else
          rd_valid_o[k] = rd_en_i[k] & vld[e];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_valid_table.sv
// Self-checking bench for valid_table: directed vector table, corner sequences, random vs model.
module tb_valid_table;
  import valid_table_pkg::*;

`ifdef VALID_TABLE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  clr_en;
  logic [11:0] clr_idx;
  logic [1:0]  set_en;
  logic [11:0] set_idx;
  logic [3:0]  rd_en;
  logic [23:0] rd_idx;
  logic [3:0]  rd_valid;
  logic        save;
  logic        restore;
  logic [6:0]  count;

  int checks   = 0;
  int failures = 0;

  bit m_vld [64];
  bit m_snap[64];

  typedef struct {
    logic [1:0] clr_en;
    vt_idx_t    clr_a, clr_b;
    logic [1:0] set_en;
    vt_idx_t    set_a, set_b;
    logic       save, restore;
    vt_idx_t    r0, r1, r2, r3;
    logic [3:0] exp_rd;
    logic [6:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  valid_table dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_en_i       (clr_en),
    .clr_idx_i      (clr_idx),
    .set_en_i       (set_en),
    .set_idx_i      (set_idx),
    .rd_en_i        (rd_en),
    .rd_idx_i       (rd_idx),
    .rd_valid_o     (rd_valid),
    .ckpt_save_i    (save),
    .ckpt_restore_i (restore),
    .count_o        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ce, input int ca, input int cb,
                              input logic [1:0] se, input int sa, input int sb,
                              input logic sv, input logic rs,
                              input int r0, input int r1, input int r2, input int r3,
                              input logic [3:0] er, input int ec);
    vec_t v;
    v.clr_en = ce;  v.clr_a = vt_idx_t'(ca); v.clr_b = vt_idx_t'(cb);
    v.set_en = se;  v.set_a = vt_idx_t'(sa); v.set_b = vt_idx_t'(sb);
    v.save = sv;    v.restore = rs;
    v.r0 = vt_idx_t'(r0); v.r1 = vt_idx_t'(r1); v.r2 = vt_idx_t'(r2); v.r3 = vt_idx_t'(r3);
    v.exp_rd = er;  v.exp_cnt = 7'(ec);
    return v;
  endfunction

  task automatic clear_ops();
    clr_en = '0; clr_idx = '0; set_en = '0; set_idx = '0;
    save = 1'b0; restore = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_vld[i]  = 1'b1;
      m_snap[i] = 1'b1;
    end
  endtask

  function automatic bit in_clr(input int idx);
    for (int p = 0; p < 2; p++)
      if (clr_en[p] && int'(clr_idx[p*6 +: 6]) == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_set(input int idx);
    for (int p = 0; p < 2; p++)
      if (set_en[p] && int'(set_idx[p*6 +: 6]) == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Applies one clock edge worth of requests to the reference table.
  task automatic model_edge();
    bit nv[64];
    for (int i = 0; i < 64; i++) begin
      if (restore)        nv[i] = m_snap[i] | in_set(i);
      else if (in_clr(i)) nv[i] = 1'b0;
      else if (in_set(i)) nv[i] = 1'b1;
      else                nv[i] = m_vld[i];
    end
    for (int i = 0; i < 64; i++) begin
      if (save && !restore) m_snap[i] = nv[i];
      else                  m_snap[i] = m_snap[i] | in_set(i);
      m_vld[i] = nv[i];
    end
  endtask

  function automatic logic [3:0] model_reads();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      int idx;
      bit v;
      idx = int'(rd_idx[k*6 +: 6]);
      v = m_vld[idx];
      if (BYP && in_set(idx) && !in_clr(idx) && !(restore && !m_snap[idx])) v = 1'b1;
      r[k] = rd_en[k] & v;
    end
    return r;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  initial begin
    // Hand-derived expectations following the zero-set of the table after reset.
    vecs[0]  = mk(2'b11, 5, 9,   2'b00, 0, 0,   0, 0,   5, 9, 4, 10,   4'b1100, 62);
    vecs[1]  = mk(2'b01, 7, 0,   2'b01, 7, 0,   0, 0,   7, 5, 9, 8,    4'b1000, 61);
    vecs[2]  = mk(2'b01, 3, 0,   2'b00, 0, 0,   0, 0,   3, 4, 5, 6,    4'b1010, 60);
    vecs[3]  = mk(2'b00, 0, 0,   2'b00, 0, 0,   1, 0,   3, 4, 5, 6,    4'b1010, 60);
    vecs[4]  = mk(2'b00, 0, 0,   2'b01, 3, 0,   0, 0,   3, 4, 5, 6,    4'b1011, 61);
    vecs[5]  = mk(2'b01, 10, 0,  2'b00, 0, 0,   0, 0,   10, 3, 5, 6,   4'b1010, 60);
    vecs[6]  = mk(2'b00, 0, 0,   2'b00, 0, 0,   0, 1,   3, 10, 5, 7,   4'b0011, 61);
    vecs[7]  = mk(2'b01, 20, 0,  2'b00, 0, 0,   0, 0,   20, 21, 22, 30, 4'b1110, 60);
    vecs[8]  = mk(2'b00, 0, 0,   2'b00, 0, 0,   1, 0,   20, 21, 22, 30, 4'b1110, 60);
    vecs[9]  = mk(2'b01, 21, 0,  2'b00, 0, 0,   0, 0,   20, 21, 22, 30, 4'b1100, 59);
    vecs[10] = mk(2'b01, 30, 0,  2'b00, 0, 0,   1, 1,   20, 21, 22, 30, 4'b1110, 60);
    vecs[11] = mk(2'b01, 22, 0,  2'b00, 0, 0,   0, 0,   20, 21, 22, 30, 4'b1010, 59);
    vecs[12] = mk(2'b00, 0, 0,   2'b00, 0, 0,   0, 1,   20, 21, 22, 30, 4'b1110, 60);
    vecs[13] = mk(2'b11, 40, 40, 2'b11, 41, 41, 0, 0,   40, 41, 5, 63,  4'b1010, 59);
    vecs[14] = mk(2'b00, 0, 0,   2'b11, 40, 5,  0, 0,   40, 5, 7, 63,   4'b1011, 61);

    rst_n = 1'b0;
    clear_ops();
    rd_en = 4'h0;
    rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset cnt", 32'(count), 32'd64);
    check("reset rd disabled", 32'(rd_valid), 32'd0);
    rd_en = 4'hf;
    rd_idx = {6'd63, 6'd33, 6'd1, 6'd0};
    #1;
    check("reset rd enabled", 32'(rd_valid), 32'hf);

    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      rd_en   = 4'h0;
      clr_en  = vecs[n].clr_en;
      clr_idx = {vecs[n].clr_b, vecs[n].clr_a};
      set_en  = vecs[n].set_en;
      set_idx = {vecs[n].set_b, vecs[n].set_a};
      save    = vecs[n].save;
      restore = vecs[n].restore;
      @(posedge clk);
      model_edge();
      #1;
      clear_ops();
      rd_en  = 4'hf;
      rd_idx = {vecs[n].r3, vecs[n].r2, vecs[n].r1, vecs[n].r0};
      #1;
      check($sformatf("vec%0d rd", n), 32'(rd_valid), 32'(vecs[n].exp_rd));
      check($sformatf("vec%0d cnt", n), 32'(count), 32'(vecs[n].exp_cnt));
    end

    // Same-cycle set and read of a cleared entry.
    @(negedge clk);
    clear_ops();
    clr_en = 2'b01; clr_idx = 12'd12;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    clear_ops();
    set_en = 2'b10; set_idx = {6'd12, 6'd0};
    rd_en = 4'b0001; rd_idx = 24'd12;
    #1;
    check("bypass same cycle", 32'(rd_valid[0]), 32'(BYP));
    @(posedge clk);
    model_edge();
    #1;
    check("set next cycle", 32'(rd_valid[0]), 32'd1);

    // Asynchronous reset in the middle of a cycle with a restore and clear pending.
    @(negedge clk);
    clear_ops();
    restore = 1'b1;
    clr_en = 2'b01; clr_idx = 12'd9;
    rd_en = 4'hf; rd_idx = {6'd20, 6'd9, 6'd5, 6'd7};
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst cnt", 32'(count), 32'd64);
    check("async rst rd", 32'(rd_valid), 32'hf);
    @(posedge clk);
    @(negedge clk);
    clear_ops();
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("post rst cnt", 32'(count), 32'd64);
    check("post rst rd", 32'(rd_valid), 32'hf);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      clr_en  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      clr_idx = 12'($urandom);
      set_en  = {($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0)};
      set_idx = 12'($urandom);
      save    = ($urandom_range(0, 7) == 0);
      restore = ($urandom_range(0, 15) == 0);
      rd_en   = 4'($urandom);
      rd_idx  = 24'($urandom);
      if ($urandom_range(0, 1) == 1) rd_idx[5:0] = set_idx[5:0];
      if ($urandom_range(0, 1) == 1) rd_idx[11:6] = clr_idx[5:0];
      #1;
      check($sformatf("rand%0d rd", n), 32'(rd_valid), 32'(model_reads()));
      check($sformatf("rand%0d cnt", n), 32'(count), 32'(model_count()));
      @(posedge clk);
      model_edge();
    end
    #1;
    check("final cnt", 32'(count), 32'(model_count()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
